// File: rtl/alu_ctrl_muldiv_if.sv
// Decoder/EX-side bundle for alu_ctrl_muldiv: decode fields, operand handshake and result handshake.
interface alu_ctrl_muldiv_if #(parameter int DATA_W = 64);
  logic [1:0]        alu_op;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        optype;
  logic              is_md;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] rs1;
  logic [DATA_W-1:0] rs2;
  logic              flush;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;

  modport master (
    output alu_op, funct3, funct7, in_valid, rs1, rs2, flush, out_ready,
    input  optype, is_md, in_ready, busy, out_valid, result
  );
  modport slave (
    input  alu_op, funct3, funct7, in_valid, rs1, rs2, flush, out_ready,
    output optype, is_md, in_ready, busy, out_valid, result
  );
endinterface

// File: rtl/alu_ctrl_muldiv.sv
// ALU control decode plus an iterative RV M-extension engine (shift-add multiply, restoring divide).
// One shared hi/lo register pair holds the product or remainder/quotient while in CALC.
module alu_ctrl_muldiv #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input logic clk,
  input logic rst,
  alu_ctrl_muldiv_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg1_q, neg1_d, neg2_q, neg2_d, dz_q, dz_d, ovf_q, ovf_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d;

  logic              md;
  logic [4:0]        opt;
  logic              s1, s2, n1, n2;
  logic [DATA_W-1:0] mag1, mag2, nhi, nlo, q_s, r_s, fin;
  logic [DATA_W:0]   sum, sh, diff;
  logic [2*DATA_W-1:0] prod, prod_s;

  always_comb begin
    md = (bus.alu_op == 2'b10) && (bus.funct7 == 7'b0000001);
    if (bus.alu_op == 2'b00)      opt = 5'b00000;
    else if (bus.alu_op == 2'b11) opt = {2'b11, bus.funct3};
    else if (md)                  opt = {2'b10, bus.funct3};
    else if (bus.funct7[5] && (bus.alu_op == 2'b10 || (bus.alu_op == 2'b01 && bus.funct3 == 3'b101)))
                                  opt = {2'b01, bus.funct3};
    else                          opt = {2'b00, bus.funct3};
  end

  // Signedness of each operand as implied by funct3 (MUL/MULHU/DIVU/REMU are unsigned).
  always_comb begin
    s1   = bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
    s2   = bus.funct3 inside {3'b001, 3'b100, 3'b110};
    n1   = s1 & bus.rs1[DATA_W-1];
    n2   = s2 & bus.rs2[DATA_W-1];
    mag1 = n1 ? -bus.rs1 : bus.rs1;
    mag2 = n2 ? -bus.rs2 : bus.rs2;
  end

  // One iteration of the datapath; f3_q[2] picks divide over multiply.
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    sh   = {hi_q, lo_q[DATA_W-1]};
    diff = sh - {1'b0, b_q};
    if (!f3_q[2]) begin
      nhi = sum[DATA_W:1];
      nlo = {sum[0], lo_q[DATA_W-1:1]};
    end else if (diff[DATA_W]) begin
      nhi = sh[DATA_W-1:0];
      nlo = {lo_q[DATA_W-2:0], 1'b0};
    end else begin
      nhi = diff[DATA_W-1:0];
      nlo = {lo_q[DATA_W-2:0], 1'b1};
    end
    prod   = {nhi, nlo};
    prod_s = (neg1_q ^ neg2_q) ? -prod : prod;
    q_s    = (neg1_q ^ neg2_q) ? -nlo : nlo;
    r_s    = neg1_q ? -nhi : nhi;
    if (!f3_q[2]) fin = (f3_q[1:0] == 2'b00) ? prod_s[DATA_W-1:0] : prod_s[2*DATA_W-1:DATA_W];
    else          fin = f3_q[1] ? r_s : q_s;
  end

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; f3_d = f3_q;
    neg1_d = neg1_q; neg2_d = neg2_q; dz_d = dz_q; ovf_d = ovf_q;
    a_d = a_q; b_d = b_q; hi_d = hi_q; lo_d = lo_q; res_d = res_q;
    case (state_q)
      S_IDLE: if (!bus.flush && bus.in_valid && md) begin
        state_d = S_CALC;
        cnt_d   = '0;
        f3_d    = bus.funct3;
        neg1_d  = n1;
        neg2_d  = n2;
        a_d     = bus.rs1;
        b_d     = mag2;
        hi_d    = '0;
        lo_d    = mag1;
        dz_d    = bus.funct3[2] && (bus.rs2 == '0);
        ovf_d   = bus.funct3[2] && !bus.funct3[0] && (bus.rs1 == MIN) && (&bus.rs2);
      end
      S_CALC: begin
        if (bus.flush) state_d = S_IDLE;
        else if (dz_q) begin
          res_d   = f3_q[1] ? a_q : '1;
          state_d = S_DONE;
        end else if (ovf_q) begin
          res_d   = f3_q[1] ? '0 : a_q;
          state_d = S_DONE;
        end else begin
          hi_d  = nhi;
          lo_d  = nlo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            res_d   = fin;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  if (bus.flush || bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE; cnt_q <= '0; f3_q <= '0;
      neg1_q <= 1'b0; neg2_q <= 1'b0; dz_q <= 1'b0; ovf_q <= 1'b0;
      a_q <= '0; b_q <= '0; hi_q <= '0; lo_q <= '0; res_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; f3_q <= f3_d;
      neg1_q <= neg1_d; neg2_q <= neg2_d; dz_q <= dz_d; ovf_q <= ovf_d;
      a_q <= a_d; b_q <= b_d; hi_q <= hi_d; lo_q <= lo_d; res_q <= res_d;
    end
  end

  assign bus.is_md     = md;
  assign bus.optype    = opt;
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_CALC);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = res_q;
endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed bench for alu_ctrl_muldiv: 64-bit and 8-bit instances, scoreboard of expected M-op results.
module tb_alu_ctrl_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  alu_ctrl_muldiv_if #(.DATA_W(64)) b64();
  alu_ctrl_muldiv_if #(.DATA_W(8))  b8();
  alu_ctrl_muldiv #(.DATA_W(64)) u64 (.clk(clk), .rst(rst), .bus(b64));
  alu_ctrl_muldiv #(.DATA_W(8))  u8  (.clk(clk), .rst(rst), .bus(b8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ov(input bit w8);
    return w8 ? b8.out_valid : b64.out_valid;
  endfunction
  function automatic logic [63:0] res(input bit w8);
    return w8 ? {56'h0, b8.result} : b64.result;
  endfunction
  function automatic logic rdy(input bit w8);
    return w8 ? b8.in_ready : b64.in_ready;
  endfunction
  function automatic logic bsy(input bit w8);
    return w8 ? b8.busy : b64.busy;
  endfunction

  task automatic drive(input bit w8, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    if (w8) begin
      b8.alu_op = 2'b10; b8.funct7 = 7'h01; b8.funct3 = f3;
      b8.rs1 = a[7:0]; b8.rs2 = b[7:0]; b8.in_valid = 1'b1;
    end else begin
      b64.alu_op = 2'b10; b64.funct7 = 7'h01; b64.funct3 = f3;
      b64.rs1 = a; b64.rs2 = b; b64.in_valid = 1'b1;
    end
  endtask

  // Accept one op, measure latency to out_valid, optionally hold off out_ready, then retire it.
  task automatic run_op(input bit w8, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                        input int lat, input logic [63:0] exp, input int hold, input string tag);
    int cyc;
    logic [63:0] got, want;
    sb.push_back(exp);
    @(negedge clk);
    drive(w8, f3, a, b);
    @(posedge clk);
    @(negedge clk);
    b8.in_valid = 1'b0; b64.in_valid = 1'b0;
    b64.rs1 = {$urandom, $urandom}; b64.rs2 = {$urandom, $urandom}; b64.funct3 = 3'($urandom);
    b8.rs1 = 8'($urandom); b8.rs2 = 8'($urandom); b8.funct3 = 3'($urandom);
    chk({tag, "_busy"}, 64'(bsy(w8)), 64'd1);
    cyc = 0;
    do begin
      @(posedge clk); cyc++; @(negedge clk);
    end while (!ov(w8) && cyc < 300);
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    got  = res(w8);
    want = sb.pop_front();
    chk(tag, got, want);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk({tag, "_hold_res"}, res(w8), want);
      chk({tag, "_hold_vld"}, 64'(ov(w8)), 64'd1);
      chk({tag, "_hold_rdy"}, 64'(rdy(w8)), 64'd0);
    end
    b8.out_ready = 1'b1; b64.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    b8.out_ready = 1'b0; b64.out_ready = 1'b0;
    chk({tag, "_retire"}, {62'h0, ov(w8), rdy(w8)}, 64'b01);
  endtask

  initial begin
    int cyc;
    b64.alu_op = 2'b00; b64.funct3 = 3'b000; b64.funct7 = 7'h00; b64.in_valid = 1'b0;
    b64.rs1 = '0; b64.rs2 = '0; b64.flush = 1'b0; b64.out_ready = 1'b0;
    b8.alu_op = 2'b00; b8.funct3 = 3'b000; b8.funct7 = 7'h00; b8.in_valid = 1'b0;
    b8.rs1 = '0; b8.rs2 = '0; b8.flush = 1'b0; b8.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", {b64.result, 1'b0}, {64'h0, 1'b0});
    chk("rst_flags", {61'h0, b64.in_ready, b64.busy, b64.out_valid}, 64'b100);
    rst = 1'b0;

    // decode sweep
    b64.alu_op = 2'b11; b64.funct3 = 3'b001; b64.funct7 = 7'h00; #1;
    chk("dec_branch", 64'(b64.optype), 64'b11001);
    b64.alu_op = 2'b10; b64.funct3 = 3'b000; b64.funct7 = 7'b0100000; #1;
    chk("dec_sub", 64'(b64.optype), 64'b01000);
    b64.alu_op = 2'b10; b64.funct3 = 3'b100; b64.funct7 = 7'b0000001; #1;
    chk("dec_md", {58'h0, b64.is_md, b64.optype}, {58'h0, 1'b1, 5'b10100});
    b64.alu_op = 2'b01; b64.funct3 = 3'b101; b64.funct7 = 7'b0100000; #1;
    chk("dec_srai", 64'(b64.optype), 64'b01101);
    b64.alu_op = 2'b00; b64.funct3 = 3'b111; b64.funct7 = 7'b0100000; #1;
    chk("dec_ldst", {58'h0, b64.is_md, b64.optype}, 64'h0);

    // multiply
    run_op(0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64, 64'hFFFF_FFFF_FFFF_FFFE, 0, "mul");
    run_op(0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64, 64'h1, 0, "mulhu");
    run_op(0, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64, 64'hFFFF_FFFF_FFFF_FFFF, 0, "mulh");
    // divide
    run_op(0, 3'b100, -64'sd7, 64'd2, 64, -64'sd3, 0, "div");
    run_op(0, 3'b110, -64'sd7, 64'd2, 64, -64'sd1, 0, "rem");
    run_op(0, 3'b101, 64'd7, 64'd2, 64, 64'd3, 0, "divu");
    run_op(0, 3'b111, 64'd7, 64'd2, 64, 64'd1, 0, "remu");
    // fast-path cases
    run_op(0, 3'b100, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, "div0");
    run_op(0, 3'b110, 64'd5, 64'd0, 1, 64'd5, 0, "rem0");
    run_op(0, 3'b101, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, "divu0");
    run_op(0, 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000, 0, "div_ovf");
    run_op(0, 3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0, 0, "rem_ovf");
    // backpressure
    run_op(0, 3'b000, 64'd1234, 64'd1000, 64, 64'd1234000, 5, "bp");

    // flush at CALC cycle 10: result register keeps the previous value
    @(negedge clk);
    drive(0, 3'b100, 64'd100, 64'd7);
    @(posedge clk); @(negedge clk);
    b64.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush_pre_busy", 64'(b64.busy), 64'd1);
    b64.flush = 1'b1;
    @(posedge clk); @(negedge clk);
    b64.flush = 1'b0;
    chk("flush_state", {61'h0, b64.in_ready, b64.busy, b64.out_valid}, 64'b100);
    chk("flush_res", b64.result, 64'd1234000);
    cyc = 0;
    repeat (70) begin
      @(negedge clk);
      if (b64.out_valid) cyc++;
    end
    chk("flush_no_valid", 64'(cyc), 64'd0);
    // flush in IDLE blocks acceptance
    drive(0, 3'b000, 64'd3, 64'd5);
    b64.flush = 1'b1;
    @(posedge clk); @(negedge clk);
    b64.flush = 1'b0; b64.in_valid = 1'b0;
    chk("flush_idle", {62'h0, b64.in_ready, b64.busy}, 64'b10);
    run_op(0, 3'b000, 64'd3, 64'd5, 64, 64'd15, 0, "after_flush");

    // async reset mid-CALC
    @(negedge clk);
    drive(0, 3'b000, 64'd9, 64'd9);
    @(posedge clk); @(negedge clk);
    b64.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_flags", {61'h0, b64.in_ready, b64.busy, b64.out_valid}, 64'b100);
    chk("arst_res", b64.result, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // 8-bit instance: -128 * 255 = -32640 = 0x8080, high byte 0x80
    run_op(1, 3'b010, 64'h80, 64'hFF, 8, 64'h80, 0, "mulhsu8");
    run_op(1, 3'b000, 64'h0D, 64'h0B, 8, 64'h8F, 0, "mul8");
    run_op(1, 3'b100, 64'h80, 64'hFF, 1, 64'h80, 0, "div8_ovf");
    run_op(1, 3'b110, 64'hF9, 64'h02, 8, 64'hFF, 0, "rem8");

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
